branch_condition_unit: RTL and testbench

// - Reads the PSR: on a control-unit request, samples status[4:0] and resolves a branch cond field to taken/not-taken.
// - Sits between the PSR and the microsequencer; holds the result until acknowledged.
// - Keeps a saturating taken-branch statistics counter.

---
 rtl/branch_condition_unit_if.sv | 26 ++
 rtl/branch_condition_unit.sv | 157 +++++++++++++++
 tb/tb_branch_condition_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/branch_condition_unit_if.sv
// Bus between the control unit / PSR side and the branch condition unit.
// The master drives the request, cond, PSR status, ack and clear inputs; the slave returns the result.
interface branch_condition_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic             req;
    logic [3:0]       cond;
    logic [4:0]       status;
    logic             ack;
    logic             cnt_clr;
    logic             busy;
    logic             valid;
    logic             taken;
    logic             illegal;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output req, cond, status, ack, cnt_clr,
        input  busy, valid, taken, illegal, taken_cnt
    );

    modport slave (
        input  req, cond, status, ack, cnt_clr,
        output busy, valid, taken, illegal, taken_cnt
    );
endinterface

// File: rtl/branch_condition_unit.sv
// Resolves a SPARC-style branch cond field against the PSR flags and holds the result until ack.
// Define BCU_FULL_COND_EN to support all 16 cond codes; otherwise only be/bcs/bneg/bvs/ba are legal.
module branch_condition_unit #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned SETTLE = 1   // 0..3
) (
    input logic                    clk,
    input logic                    reset,
    branch_condition_unit_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_EVAL,
        S_DONE
    } state_e;

    localparam logic [1:0] SETTLE_LD = 2'(SETTLE);

    state_e           state_q, state_d;
    logic [1:0]       settle_q, settle_d;
    logic [3:0]       cond_q, cond_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             taken_q, taken_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic flag_n, flag_z, flag_c, flag_v;
    logic eval_taken, eval_illegal;
    logic unused_disp;

    assign flag_n      = bus.status[0];
    assign flag_z      = bus.status[1];
    assign flag_c      = bus.status[2];
    assign flag_v      = bus.status[3];
    assign unused_disp = bus.status[4];

    always_comb begin
        eval_taken   = 1'b0;
        eval_illegal = 1'b0;
`ifdef BCU_FULL_COND_EN
        case (cond_q)
            4'h0:    eval_taken = 1'b0;
            4'h1:    eval_taken = flag_z;
            4'h2:    eval_taken = flag_z | (flag_n ^ flag_v);
            4'h3:    eval_taken = flag_n ^ flag_v;
            4'h4:    eval_taken = flag_c | flag_z;
            4'h5:    eval_taken = flag_c;
            4'h6:    eval_taken = flag_n;
            4'h7:    eval_taken = flag_v;
            4'h8:    eval_taken = 1'b1;
            4'h9:    eval_taken = ~flag_z;
            4'hA:    eval_taken = ~(flag_z | (flag_n ^ flag_v));
            4'hB:    eval_taken = ~(flag_n ^ flag_v);
            4'hC:    eval_taken = ~(flag_c | flag_z);
            4'hD:    eval_taken = ~flag_c;
            4'hE:    eval_taken = ~flag_n;
            default: eval_taken = ~flag_v;
        endcase
`else
        case (cond_q)
            4'h1:    eval_taken = flag_z;
            4'h5:    eval_taken = flag_c;
            4'h6:    eval_taken = flag_n;
            4'h7:    eval_taken = flag_v;
            4'h8:    eval_taken = 1'b1;
            default: eval_illegal = 1'b1;
        endcase
`endif
    end

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        cond_d      = cond_q;
        busy_d      = busy_q;
        valid_d     = valid_q;
        taken_d     = taken_q;
        illegal_d   = illegal_q;
        taken_cnt_d = taken_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    cond_d = bus.cond;
                    busy_d = 1'b1;
                    if (SETTLE == 0) begin
                        state_d = S_EVAL;
                    end else begin
                        state_d  = S_SETTLE;
                        settle_d = SETTLE_LD;
                    end
                end
            end
            S_SETTLE: begin
                // Settle lasts exactly SETTLE cycles: leave when the last count is consumed.
                if (settle_q <= 2'd1) begin
                    state_d  = S_EVAL;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q - 2'd1;
                end
            end
            S_EVAL: begin
                state_d   = S_DONE;
                busy_d    = 1'b0;
                valid_d   = 1'b1;
                taken_d   = eval_taken;
                illegal_d = eval_illegal;
                if (eval_taken && (taken_cnt_q != '1)) begin
                    taken_cnt_d = taken_cnt_q + 1'b1;
                end
            end
            default: begin
                if (bus.ack) begin
                    state_d   = S_IDLE;
                    valid_d   = 1'b0;
                    taken_d   = 1'b0;
                    illegal_d = 1'b0;
                end
            end
        endcase

        if (bus.cnt_clr) begin
            taken_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            settle_q    <= '0;
            cond_q      <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            taken_q     <= 1'b0;
            illegal_q   <= 1'b0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            cond_q      <= cond_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            taken_q     <= taken_d;
            illegal_q   <= illegal_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.valid     = valid_q;
    assign bus.taken     = taken_q;
    assign bus.illegal   = illegal_q;
    assign bus.taken_cnt = taken_cnt_q;
endmodule

// File: tb/tb_branch_condition_unit.sv
// Scoreboard bench for branch_condition_unit: driver pushes expected results, a negedge monitor pops and compares.
module tb_branch_condition_unit;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned SETTLE = 1;

    typedef struct {
        logic             taken;
        logic             illegal;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    branch_condition_unit_if #(.CNT_W(CNT_W)) bus ();

    branch_condition_unit #(.CNT_W(CNT_W), .SETTLE(SETTLE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sb[$];
    int unsigned model_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // SPARC structure: codes 8..15 are the complements of codes 0..7.
    function automatic void ref_resolve(input logic [3:0] c, input logic [4:0] s,
                                        output logic tk, output logic il);
        logic       n, z, cy, v;
        logic [7:0] base;
        logic       full;
        n    = s[0];
        z    = s[1];
        cy   = s[2];
        v    = s[3];
        base = {v, n, cy, cy | z, n ^ v, z | (n ^ v), z, 1'b0};
        full = base[c[2:0]] ^ c[3];
`ifdef BCU_FULL_COND_EN
        il = 1'b0;
        tk = full;
`else
        il = !(c inside {4'd1, 4'd5, 4'd6, 4'd7, 4'd8});
        tk = il ? 1'b0 : full;
`endif
    endfunction

    exp_t mon_e;
    logic valid_prev = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            valid_prev = 1'b0;
        end else begin
            if (bus.valid && !valid_prev) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("taken", bus.taken, mon_e.taken);
                    check("illegal", bus.illegal, mon_e.illegal);
                    check("taken_cnt", bus.taken_cnt, mon_e.cnt);
                end
            end
            valid_prev = bus.valid;
        end
    end

    // Called #1 after a posedge with the DUT idle; returns #1 after the edge that consumed ack.
    task automatic txn(input logic [3:0] c, input logic [4:0] pre, input logic [4:0] ev,
                       input logic [4:0] post, input int unsigned hold, input bit clr);
        logic        tk, il;
        int unsigned n;
        exp_t        e;
        ref_resolve(c, ev, tk, il);
        if (clr) model_cnt = 0;
        else if (tk && model_cnt < (1 << CNT_W) - 1) model_cnt++;
        e.taken   = tk;
        e.illegal = il;
        e.cnt     = model_cnt[CNT_W-1:0];
        sb.push_back(e);

        bus.req    = 1'b1;
        bus.cond   = c;
        bus.status = pre;
        @(posedge clk); #1;
        bus.req  = 1'($urandom_range(0, 1));
        bus.cond = 4'($urandom);
        check("busy_after_accept", bus.busy, 32'd1);
        n = 1;
        while (!bus.valid && n < 12) begin
            if (n == SETTLE + 1) begin
                bus.status  = ev;
                bus.cnt_clr = clr;
            end
            @(posedge clk); #1;
            n++;
            bus.cnt_clr = 1'b0;
        end
        check("latency", n, SETTLE + 2);
        check("busy_in_done", bus.busy, 32'd0);
        bus.status = post;
        repeat (hold) begin
            @(posedge clk); #1;
            bus.cond = 4'($urandom);
            check("hold_valid", bus.valid, 32'd1);
            check("hold_taken", bus.taken, tk);
            check("hold_illegal", bus.illegal, il);
            bus.status = 5'($urandom);
        end
        bus.ack = 1'b1;
        bus.req = 1'b0;
        @(posedge clk); #1;
        bus.ack = 1'b0;
        check("valid_after_ack", bus.valid, 32'd0);
        check("taken_after_ack", bus.taken, 32'd0);
        check("illegal_after_ack", bus.illegal, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req     = 1'b0;
        bus.cond    = '0;
        bus.status  = '0;
        bus.ack     = 1'b0;
        bus.cnt_clr = 1'b0;
        reset       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 32'd0);
        check("rst_valid", bus.valid, 32'd0);
        check("rst_taken", bus.taken, 32'd0);
        check("rst_illegal", bus.illegal, 32'd0);
        check("rst_cnt", bus.taken_cnt, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        txn(4'b0001, 5'b00010, 5'b00010, 5'b00010, 0, 1'b0);
        txn(4'b0101, 5'b00010, 5'b00010, 5'b00010, 1, 1'b0);
        txn(4'b1000, 5'b00010, 5'b00010, 5'b00010, 0, 1'b0);
        txn(4'b0110, 5'b00000, 5'b00001, 5'b00000, 3, 1'b0);
        txn(4'b0110, 5'b11111, 5'b10000, 5'b11111, 5, 1'b0);
        txn(4'b1001, 5'b00000, 5'b00000, 5'b00010, 2, 1'b0);
        txn(4'b0111, 5'b00000, 5'b01000, 5'b00000, 1, 1'b0);

        // Asynchronous reset while the request is settling, with a nonzero counter.
        bus.req  = 1'b1;
        bus.cond = 4'b1000;
        @(posedge clk); #1;
        bus.req = 1'b0;
        check("busy_before_reset", bus.busy, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy", bus.busy, 32'd0);
        check("mid_rst_valid", bus.valid, 32'd0);
        check("mid_rst_taken", bus.taken, 32'd0);
        check("mid_rst_illegal", bus.illegal, 32'd0);
        check("mid_rst_cnt", bus.taken_cnt, 32'd0);
        model_cnt = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        txn(4'b0001, 5'b00000, 5'b00010, 5'b00000, 0, 1'b0);

        txn(4'b1000, 5'b00000, 5'b00000, 5'b00000, 0, 1'b1);
        repeat (4) txn(4'b1000, 5'($urandom), 5'($urandom), 5'($urandom), 0, 1'b0);
        txn(4'b1000, 5'b00000, 5'b00000, 5'b00000, 0, 1'b1);

        for (int i = 0; i < 60; i++) begin
            txn(4'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                $urandom_range(0, 5), ($urandom_range(0, 7) == 0));
        end

        @(posedge clk); #1;
        check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
